cipher_uart_rx: RTL
===================

CIPHER_UART_RX -- requirements
Module: cipher_uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit (12 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high, LSB first.
REQ-005 SHALL have port byte_out  output  8  received ciphertext byte; feeds the decrypt stage inp.
REQ-006 SHALL have port byte_valid  output  1  byte_out holds an unconsumed byte.
REQ-007 SHALL have port byte_ready  input  1  consumer accepts byte_out this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: completed byte dropped because the buffer was full.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; rx_s resets to 1.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-012 IDLE: rx_s==0 -> START, bit counter cleared; otherwise remain.
REQ-013 START: after CLKS_PER_BIT/2 (floor) cycles, sample rx_s; 0 -> DATA, 1 -> IDLE (false start, no output, no flag).
REQ-014 DATA: sample rx_s every CLKS_PER_BIT cycles into shift register LSB first; after the 8th sample -> STOP.
REQ-015 STOP: CLKS_PER_BIT cycles after the 8th data sample, sample rx_s; 1 -> byte complete, go IDLE; 0 -> frame_err=1 for exactly one cycle, byte discarded, go BREAK.
REQ-016 BREAK: remain until rx_s==1, then IDLE; no start detection while in BREAK.
REQ-017 Byte complete with byte_valid==0: byte_out loaded, byte_valid=1 on the next cycle.
REQ-018 byte_valid SHALL stay high and byte_out stable until a cycle with byte_valid && byte_ready; byte_valid clears on the following edge.
REQ-019 Byte complete with byte_valid==1 and byte_ready==0 in the same cycle: new byte dropped, byte_out unchanged, overrun=1 for exactly one cycle.
REQ-020 Byte complete with byte_valid==1 and byte_ready==1 in the same cycle: old byte consumed, new byte loaded, byte_valid stays 1, no overrun.
REQ-021 byte_ready while byte_valid==0 SHALL have no effect.
REQ-022 Bit timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at every sample; no wrap-around drift across a frame.
REQ-023 Latency: byte_valid rises 1 clk after the stop-bit sample edge (rx-to-rx_s delay is 2 clk).
REQ-024 frame_err and overrun SHALL never be high in the same cycle as a byte_valid rising edge caused by the same frame.

Reset
REQ-025 On rst==1 at a clk edge: state=IDLE, timers and bit counter=0, shift register=0x00, byte_out=0x00, byte_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-026 rst mid-frame SHALL abandon the frame silently; no byte, no flag emitted for it after rst deasserts.
REQ-027 rst has priority over every other event in the same cycle.

Verification (CLKS_PER_BIT=8)
REQ-028 Send 0xA5 (8N1), byte_ready=1 -> byte_out=0xA5, byte_valid high exactly 1 cycle, no flags.
REQ-029 rx low pulse of 2 cycles in IDLE -> no byte_valid, no frame_err; following frame 0x3C received correctly.
REQ-030 Send 0x5A with stop bit forced low, rx held low 20 cycles then high -> one frame_err pulse, no byte_valid; next frame 0x81 received correctly.
REQ-031 byte_ready=0; send 0x3C then 0xC3 -> byte_out=0x3C, byte_valid held, one overrun pulse at 0xC3 completion; raise byte_ready -> byte_valid clears next cycle.
REQ-032 byte_ready asserted in the exact cycle 0xC3 completes while 0x3C is pending -> byte_out=0xC3, byte_valid stays 1, overrun stays 0.
REQ-033 Assert rst for 1 cycle during the 4th data bit of 0xFF -> all outputs reset values, no byte for that frame; next frame 0x00 received as 0x00.

Source files
------------

// File: rtl/cipher_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : cipher_uart_rx
//  Description : 8N1 UART receiver feeding the decrypt stage. It passes rx
//                through a two-flop synchroniser, checks the start bit at
//                mid-bit and then samples each bit once per bit period. The
//                completed byte is held in a one-entry valid/ready buffer.
//                frame_err pulses when the stop bit is sampled low.
//                overrun pulses when a completed byte is dropped because
//                the buffer is full.
//  Ports       : clk        - sole clock, rising edge
//                rst        - synchronous active-high reset
//                rx         - asynchronous serial line, idle high, LSB first
//                byte_out   - received ciphertext byte
//                byte_valid - byte_out holds an unconsumed byte
//                byte_ready - consumer takes byte_out this cycle
//                frame_err  - one-cycle pulse, stop bit sampled low
//                overrun    - one-cycle pulse, completed byte dropped
//  Revision    : 1.0  initial release
// ============================================================================
module cipher_uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    // Terminal counts. The timer reloads to zero at every sample, so there
    // is no rounding drift from one bit to the next within a frame.
    localparam logic [TW-1:0] C_BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] C_HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            rx_meta_q, rx_s_q;
    logic            byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bitcnt_q  <= '0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            timer_q   <= timer_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d  = S_START;
                    timer_d  = '0;
                    bitcnt_d = '0;
                end
            end
            S_START: begin
                // Mid-bit recheck; a line that is high again is a glitch.
                if (timer_q == C_HALF_LAST) begin
                    timer_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == C_BIT_LAST) begin
                    timer_d  = '0;
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == C_BIT_LAST) begin
                    timer_d = '0;
                    if (rx_s_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_BREAK: begin
                // Wait out a held-low line so that it is not taken as a
                // string of new start bits.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // One-entry buffer. A consume in the same cycle as a completion frees
        // the slot, so the new byte goes straight in.
        if (byte_done) begin
            if (!valid_q || byte_ready) begin
                byte_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
`default_nettype wire
